// File: rtl/lap_timer_if.sv
// ---------------------------------------------------------------------------
// lap_timer_if
// Command/status bundle between the debouncer/keyboard front end and the
// lap timer, and between the lap timer and the select/FND display path.
//   i_start/i_stop/i_clear/i_lap/i_lap_rd/i_load : single-cycle command pulses
//   i_mode      : 0 = count up, 1 = count down
//   i_load_time : {hour[4:0], min[5:0], sec[5:0], sub[6:0]} preset value
//   o_time      : current time, same packing
//   o_lap_*     : lap buffer head, status and occupancy
//   o_run/o_alarm/o_tick : state flags and sub-second advance strobe
// slave = the timer itself, master = whoever drives the commands.
// ---------------------------------------------------------------------------
interface lap_timer_if #(
    parameter int LAP_DEPTH = 8
);
    localparam int CW = $clog2(LAP_DEPTH + 1);

    logic          i_start;
    logic          i_stop;
    logic          i_clear;
    logic          i_lap;
    logic          i_lap_rd;
    logic          i_mode;
    logic          i_load;
    logic [23:0]   i_load_time;
    logic [23:0]   o_time;
    logic [23:0]   o_lap_time;
    logic          o_lap_valid;
    logic          o_lap_full;
    logic [CW-1:0] o_lap_count;
    logic          o_run;
    logic          o_alarm;
    logic          o_tick;

    modport slave (
        input  i_start, i_stop, i_clear, i_lap, i_lap_rd, i_mode, i_load, i_load_time,
        output o_time, o_lap_time, o_lap_valid, o_lap_full, o_lap_count,
               o_run, o_alarm, o_tick
    );

    modport master (
        output i_start, i_stop, i_clear, i_lap, i_lap_rd, i_mode, i_load, i_load_time,
        input  o_time, o_lap_time, o_lap_valid, o_lap_full, o_lap_count,
               o_run, o_alarm, o_tick
    );
endinterface

// File: rtl/lap_timer.sv
// ---------------------------------------------------------------------------
// lap_timer
// Stopwatch / countdown timer with a circular lap buffer.
//   clk : system clock (CLK_HZ)
//   rst : asynchronous, active-low reset
//   bus : lap_timer_if.slave -- commands in, time/lap/status out
// Time advances by one sub-second unit every DIV = CLK_HZ/TICK_HZ cycles in
// RUN. Up mode wraps 23:59:59.max -> 0; down mode stops at zero and raises
// the alarm (DONE). Laps are captured into a LAP_DEPTH-entry ring that
// overwrites its oldest entry when full; the head is shown fall-through.
// ---------------------------------------------------------------------------
module lap_timer #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 8
) (
    input logic       clk,
    input logic       rst,
    lap_timer_if.slave bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CW  = $clog2(LAP_DEPTH + 1);
    localparam int SW  = CW + 1;
    localparam logic [6:0] SUB_MAX = 7'(TICK_HZ - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] sub;
    } time_t;

    state_t        state, state_nxt;
    time_t         tm, tm_step, tm_load, tm_in;
    logic [PW-1:0] presc;
    logic          mode;

    logic          idle_or_pause, mode_eff, time_zero, presc_end, tick, do_load;

    time_t         mem [LAP_DEPTH];
    logic [AW-1:0] head, head_inc, wr_ptr;
    logic [CW-1:0] cnt;
    logic [SW-1:0] wsum;
    logic          push, pop, full;

    // ---------------- control decode ----------------
    assign idle_or_pause = (state == IDLE) || (state == PAUSE);
    // Start-from-IDLE uses the mode being sampled this cycle, since the mode
    // register only catches up at the same edge.
    assign mode_eff  = idle_or_pause ? bus.i_mode : mode;
    assign time_zero = (tm == '0);
    assign presc_end = (presc == PW'(DIV - 1));
    // Stop and clear both suppress the advance scheduled for this cycle.
    assign tick      = (state == RUN) && presc_end && !bus.i_stop && !bus.i_clear;
    // Load is the lowest priority command: any higher command drops it.
    assign do_load   = bus.i_load && idle_or_pause &&
                       !bus.i_clear && !bus.i_stop && !bus.i_start;

    // ---------------- time arithmetic ----------------
    assign tm_in = time_t'(bus.i_load_time);

    always_comb begin
        tm_load.hour = (tm_in.hour > 5'd23) ? 5'd23   : tm_in.hour;
        tm_load.min  = (tm_in.min  > 6'd59) ? 6'd59   : tm_in.min;
        tm_load.sec  = (tm_in.sec  > 6'd59) ? 6'd59   : tm_in.sec;
        tm_load.sub  = (tm_in.sub  > SUB_MAX) ? SUB_MAX : tm_in.sub;
    end

    always_comb begin
        // NOTE: a full default assignment first means every path drives
        // tm_step, so no latch is inferred.
        tm_step = tm;
        if (!mode) begin
            if (tm.sub != SUB_MAX) tm_step.sub = tm.sub + 7'd1;
            else begin
                tm_step.sub = '0;
                if (tm.sec != 6'd59) tm_step.sec = tm.sec + 6'd1;
                else begin
                    tm_step.sec = '0;
                    if (tm.min != 6'd59) tm_step.min = tm.min + 6'd1;
                    else begin
                        tm_step.min  = '0;
                        tm_step.hour = (tm.hour == 5'd23) ? 5'd0 : tm.hour + 5'd1;
                    end
                end
            end
        end else if (!time_zero) begin
            // Borrow chain; a nonzero time guarantees hour never underflows.
            if (tm.sub != '0) tm_step.sub = tm.sub - 7'd1;
            else begin
                tm_step.sub = SUB_MAX;
                if (tm.sec != '0) tm_step.sec = tm.sec - 6'd1;
                else begin
                    tm_step.sec = 6'd59;
                    if (tm.min != '0) tm_step.min = tm.min - 6'd1;
                    else begin
                        tm_step.min  = 6'd59;
                        tm_step.hour = tm.hour - 5'd1;
                    end
                end
            end
        end
    end

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (bus.i_clear) state_nxt = IDLE;
        else begin
            unique case (state)
                IDLE:  if (bus.i_start && !bus.i_stop && !(mode_eff && time_zero))
                           state_nxt = RUN;
                RUN:   if (bus.i_stop) state_nxt = PAUSE;
                       else if (tick && mode && (tm_step == '0)) state_nxt = DONE;
                PAUSE: if (bus.i_start && !bus.i_stop) state_nxt = RUN;
                DONE:  state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.o_run   = (state == RUN);
        bus.o_alarm = (state == DONE);
    end

    // ---------------- time / prescaler / mode ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tm    <= '0;
            presc <= '0;
            mode  <= 1'b0;
        end else begin
            if (idle_or_pause) mode <= bus.i_mode;
            if (bus.i_clear) begin
                tm    <= '0;
                presc <= '0;
            end else if (do_load) begin
                tm    <= tm_load;
                presc <= '0;
            end else if (state == RUN && !bus.i_stop) begin
                presc <= presc_end ? '0 : presc + PW'(1);
                if (tick) tm <= tm_step;
            end
        end
    end

    // ---------------- lap ring buffer ----------------
    assign push     = bus.i_lap && (state != IDLE) && !bus.i_clear;
    assign pop      = bus.i_lap_rd && (cnt != '0) && !bus.i_clear;
    assign full     = (cnt == CW'(LAP_DEPTH));
    assign head_inc = (head == AW'(LAP_DEPTH - 1)) ? '0 : head + AW'(1);

    // Tail = (head + cnt) mod LAP_DEPTH; when full this equals head, so a
    // push overwrites exactly the entry that is being dropped or popped.
    always_comb begin
        wsum = SW'(head) + SW'(cnt);
        if (wsum >= SW'(LAP_DEPTH)) wsum = wsum - SW'(LAP_DEPTH);
        wr_ptr = wsum[AW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            cnt  <= '0;
        end else if (bus.i_clear) begin
            head <= '0;
            cnt  <= '0;
        end else begin
            if (pop || (push && full)) head <= head_inc;
            if (push && !pop && !full) cnt <= cnt + CW'(1);
            else if (pop && !push)     cnt <= cnt - CW'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; cnt gates every
    // read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tm;
    end

    // ---------------- remaining outputs ----------------
    assign bus.o_time      = tm;
    assign bus.o_tick      = tick;
    assign bus.o_lap_time  = (cnt != '0) ? mem[head] : '0;
    assign bus.o_lap_valid = (cnt != '0);
    assign bus.o_lap_full  = full;
    assign bus.o_lap_count = cnt;
endmodule

// File: tb/tb_lap_timer.sv
// ---------------------------------------------------------------------------
// tb_lap_timer
// Directed bench for lap_timer with CLK_HZ=1000, TICK_HZ=100 (DIV=10),
// LAP_DEPTH=4. Load/clamp behaviour is table driven; the multi-cycle
// behaviours (run, pause/resume, wrap, countdown alarm, lap ring, command
// collisions, asynchronous reset) are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_lap_timer;
    localparam int LAP_DEPTH = 4;

    typedef struct {
        string       name;
        logic [23:0] load_time;
        logic [23:0] exp_time;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   tick_total = 0;

    lap_timer_if #(.LAP_DEPTH(LAP_DEPTH)) bus();

    lap_timer #(
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .LAP_DEPTH(LAP_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // o_tick is counted mid-cycle, where inputs and state are stable.
    always @(negedge clk) if (bus.o_tick === 1'b1) tick_total++;

    function automatic logic [23:0] pack(input int h, input int m, input int s, input int sub);
        return {5'(h), 6'(m), 6'(s), 7'(sub)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; registered outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(); bus.i_start = 1'b1; step(); bus.i_start = 1'b0; endtask
    task automatic pulse_stop();  bus.i_stop  = 1'b1; step(); bus.i_stop  = 1'b0; endtask
    task automatic pulse_clear(); bus.i_clear = 1'b1; step(); bus.i_clear = 1'b0; endtask
    task automatic pulse_lap();   bus.i_lap   = 1'b1; step(); bus.i_lap   = 1'b0; endtask
    task automatic pulse_pop();   bus.i_lap_rd = 1'b1; step(); bus.i_lap_rd = 1'b0; endtask

    task automatic do_load(input logic [23:0] t);
        bus.i_load_time = t;
        bus.i_load = 1'b1;
        step();
        bus.i_load = 1'b0;
    endtask

    vec_t        vecs [5];
    logic [23:0] laps [4];
    int          tick_base;

    initial begin
        vecs[0] = '{"load_plain",   pack(12, 34, 56, 78), pack(12, 34, 56, 78)};
        vecs[1] = '{"load_sec63",   pack(0, 0, 63, 5),    pack(0, 0, 59, 5)};
        vecs[2] = '{"load_all_max", pack(31, 63, 63, 127), pack(23, 59, 59, 99)};
        vecs[3] = '{"load_top",     pack(23, 59, 59, 99), pack(23, 59, 59, 99)};
        vecs[4] = '{"load_sub100",  pack(0, 0, 0, 100),   pack(0, 0, 0, 99)};

        bus.i_start = 0; bus.i_stop = 0; bus.i_clear = 0; bus.i_lap = 0;
        bus.i_lap_rd = 0; bus.i_mode = 0; bus.i_load = 0; bus.i_load_time = '0;

        // ---- reset state ----
        #12;
        check("rst_time",      bus.o_time, 0);
        check("rst_run",       bus.o_run, 0);
        check("rst_alarm",     bus.o_alarm, 0);
        check("rst_tick",      bus.o_tick, 0);
        check("rst_lap_valid", bus.o_lap_valid, 0);
        check("rst_lap_full",  bus.o_lap_full, 0);
        check("rst_lap_count", bus.o_lap_count, 0);
        check("rst_lap_time",  bus.o_lap_time, 0);
        #10 rst = 1'b1;
        step();

        // ---- load / clamp table ----
        foreach (vecs[i]) begin
            do_load(vecs[i].load_time);
            check(vecs[i].name, bus.o_time, vecs[i].exp_time);
            check({vecs[i].name, "_run"}, bus.o_run, 0);
        end
        pulse_clear();
        check("clear_time", bus.o_time, 0);

        // ---- start, 1000 cycles, stop ----
        tick_base = tick_total;
        pulse_start();
        check("run_after_start", bus.o_run, 1);
        repeat (9) step();
        check("no_adv_before_div", bus.o_time, 0);
        step();
        check("first_adv_at_div", bus.o_time, pack(0, 0, 0, 1));
        repeat (990) step();
        pulse_stop();
        check("time_1s", bus.o_time, pack(0, 0, 1, 0));
        check("ticks_100", tick_total - tick_base, 100);
        check("run_after_stop", bus.o_run, 0);

        // ---- pause with prescaler at 6, resume ----
        pulse_start();
        repeat (6) step();
        pulse_stop();
        repeat (50) step();
        check("pause_hold", bus.o_time, pack(0, 0, 1, 0));
        pulse_start();
        repeat (3) step();
        check("resume_pre_adv", bus.o_time, pack(0, 0, 1, 0));
        check("resume_tick", bus.o_tick, 1);
        step();
        check("resume_adv_4", bus.o_time, pack(0, 0, 1, 1));

        // ---- stop in the same cycle as a tick ----
        repeat (9) step();
        check("tick_before_stop", bus.o_tick, 1);
        bus.i_stop = 1'b1;
        #1;
        check("stop_kills_tick", bus.o_tick, 0);
        step();
        bus.i_stop = 1'b0;
        check("stop_tick_no_adv", bus.o_time, pack(0, 0, 1, 1));
        check("stop_tick_paused", bus.o_run, 0);
        pulse_clear();

        // ---- up-mode wrap at 23:59:59.99 ----
        do_load(pack(23, 59, 59, 99));
        pulse_start();
        repeat (10) step();
        check("wrap_to_zero", bus.o_time, 0);
        check("wrap_keeps_run", bus.o_run, 1);
        check("wrap_no_alarm", bus.o_alarm, 0);
        step();
        pulse_clear();

        // ---- countdown to alarm ----
        bus.i_mode = 1'b1;
        do_load(pack(0, 0, 0, 3));
        pulse_start();
        repeat (29) step();
        check("down_last_tick", bus.o_tick, 1);
        check("down_before_zero", bus.o_time, pack(0, 0, 0, 1));
        check("down_alarm_pre", bus.o_alarm, 0);
        step();
        check("down_zero", bus.o_time, 0);
        check("down_alarm", bus.o_alarm, 1);
        check("down_run_off", bus.o_run, 0);
        pulse_start();
        check("done_ignores_start", bus.o_alarm, 1);
        check("done_run_off", bus.o_run, 0);
        pulse_clear();
        check("clear_alarm", bus.o_alarm, 0);
        check("clear_run", bus.o_run, 0);

        // ---- down mode, time 0, start ignored ----
        pulse_start();
        check("down_zero_start", bus.o_run, 0);
        step();
        check("down_zero_idle", bus.o_run, 0);

        // ---- lap ring: 6 pushes into depth 4 ----
        bus.i_mode = 1'b0;
        step();
        pulse_lap();
        check("lap_idle_ignored", bus.o_lap_count, 0);
        pulse_start();
        for (int j = 0; j < 6; j++) begin
            repeat (10) step();
            pulse_lap();
            if (j >= 2) laps[j - 2] = pack(0, 0, 0, j + 1);
        end
        check("lap_count_4", bus.o_lap_count, 4);
        check("lap_full", bus.o_lap_full, 1);
        check("lap_head_3rd", bus.o_lap_time, laps[0]);

        // push + pop while full at time .07: oldest popped, .07 appended
        repeat (10) step();
        bus.i_lap = 1'b1; bus.i_lap_rd = 1'b1;
        step();
        bus.i_lap = 1'b0; bus.i_lap_rd = 1'b0;
        check("pushpop_count", bus.o_lap_count, 4);
        check("pushpop_head", bus.o_lap_time, laps[1]);
        laps[0] = laps[1]; laps[1] = laps[2]; laps[2] = laps[3];
        laps[3] = pack(0, 0, 0, 7);
        pulse_stop();

        for (int k = 0; k < 4; k++) begin
            check($sformatf("pop_%0d_time", k), bus.o_lap_time, laps[k]);
            check($sformatf("pop_%0d_valid", k), bus.o_lap_valid, 1);
            pulse_pop();
        end
        check("empty_valid", bus.o_lap_valid, 0);
        check("empty_count", bus.o_lap_count, 0);
        check("empty_time", bus.o_lap_time, 0);
        pulse_pop();
        check("pop_empty_count", bus.o_lap_count, 0);
        check("pop_empty_valid", bus.o_lap_valid, 0);

        // ---- clear + lap + start together ----
        pulse_lap();
        check("lap_in_pause", bus.o_lap_count, 1);
        bus.i_clear = 1'b1; bus.i_lap = 1'b1; bus.i_start = 1'b1;
        step();
        bus.i_clear = 1'b0; bus.i_lap = 1'b0; bus.i_start = 1'b0;
        check("cls_run", bus.o_run, 0);
        check("cls_time", bus.o_time, 0);
        check("cls_count", bus.o_lap_count, 0);
        check("cls_valid", bus.o_lap_valid, 0);
        step();
        check("cls_stays_idle", bus.o_run, 0);

        // ---- asynchronous reset mid-run ----
        pulse_start();
        repeat (12) step();
        pulse_lap();
        check("pre_rst_lap", bus.o_lap_time, pack(0, 0, 0, 1));
        #2 rst = 1'b0;
        #1;
        check("arst_time", bus.o_time, 0);
        check("arst_run", bus.o_run, 0);
        check("arst_count", bus.o_lap_count, 0);
        check("arst_valid", bus.o_lap_valid, 0);
        check("arst_lap_time", bus.o_lap_time, 0);
        check("arst_tick", bus.o_tick, 0);
        #1 rst = 1'b1;
        step();
        check("post_rst_idle", bus.o_run, 0);
        repeat (15) step();
        check("post_rst_time", bus.o_time, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lap_timer.md
# lap_timer

Parametrised successor to the current stopwatch datapath/control pair. It counts up (stopwatch) or down (countdown timer with alarm) in hour:min:sec:sub-second fields. It also holds a lap buffer of up to LAP_DEPTH captured times. It sits behind the button debouncers and keyboard strobes and feeds the existing select/FND path with the same 24-bit packed time format.

## Interface
- CLK_HZ, 100_000_000, input clock frequency in Hz
- TICK_HZ, 100, sub-second field rate; legal range 2..100; CLK_HZ must be an integer multiple of it
- LAP_DEPTH, 8, lap buffer entries; legal range 1..16
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- i_start  in  1  single-cycle pulse: run/resume
- i_stop  in  1  single-cycle pulse: pause
- i_clear  in  1  single-cycle pulse: zero time, flush laps, go idle
- i_lap  in  1  single-cycle pulse: capture current time into lap buffer
- i_lap_rd  in  1  single-cycle pulse: pop lap buffer head
- i_mode  in  1  0 = count up, 1 = count down; sampled only in IDLE/PAUSE
- i_load  in  1  single-cycle pulse: load i_load_time; honoured only in IDLE/PAUSE
- i_load_time  in  24  {hour[4:0], min[5:0], sec[5:0], sub[6:0]}
- o_time  out  24  current time, same packing
- o_lap_time  out  24  lap buffer head (first-word-fall-through); 0 when empty
- o_lap_valid  out  1  buffer not empty
- o_lap_full  out  1  buffer holds LAP_DEPTH entries
- o_lap_count  out  $clog2(LAP_DEPTH+1)  entries held
- o_run  out  1  state == RUN
- o_alarm  out  1  state == DONE
- o_tick  out  1  one-cycle pulse on each sub-second advance

## Operation
- Reset values:
  - all outputs 0
  - state IDLE
  - mode register 0
  - prescaler 0
  - lap buffer empty
- Fields and wrap:
  - sub field wraps at TICK_HZ-1, sec at 59, min at 59, hour at 23.
  - Up mode: 23:59:59.(TICK_HZ-1) wraps to 00:00:00.00 and keeps running.
  - Down mode: borrow chain in reverse; no wrap below zero.
- Load:
  - Each field is clamped to its maximum.
  - Clamp example: sec=63 loads as 59; sub≥TICK_HZ loads as TICK_HZ-1.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: i_start goes to RUN, except in down mode with time == 0, where it is ignored.
  - RUN: i_stop goes to PAUSE. In down mode, the tick that makes time 0 goes to DONE.
  - PAUSE: i_start goes to RUN.
  - DONE: i_start is ignored; only i_clear exits.
  - Any state: i_clear goes to IDLE, sets time to 0 and prescaler to 0, flushes laps. The mode register is kept.
- Same-cycle command priority: clear > stop > start > load.
  - Load and start in the same IDLE cycle: start wins and the load is dropped.
- Mode: the mode register updates from i_mode every cycle in IDLE/PAUSE and is frozen in RUN/DONE.
- Prescaler:
  - Counts 0..DIV-1, where DIV = CLK_HZ/TICK_HZ, only in RUN.
  - Holds its value in PAUSE, so resume continues the partial period.
  - Cleared only by reset, clear, or load.
- Lap buffer, circular:
  - i_lap is accepted in RUN, PAUSE and DONE; ignored in IDLE.
  - Push while full overwrites the oldest entry; count stays LAP_DEPTH.
  - Pop while empty is ignored.
  - Push and pop in the same cycle: head advances, new entry appended, count unchanged. This also holds when full: the oldest entry is popped, not lost twice.
  - Clear in the same cycle as lap or pop: clear wins, buffer empty.

## Timing
- Commands are sampled on the rising clk edge. State, o_run and o_alarm change at that edge and are visible in the next cycle.
- o_tick is asserted during the cycle in which prescaler == DIV-1 in RUN. o_time advances at the end of that cycle.
- Start to first time advance: DIV cycles.
- Stop in the same cycle as a tick: stop wins; no advance, no o_tick.
- Lap captures the registered o_time present in the sampling cycle. With a simultaneous tick, the pre-advance value is captured.
- o_lap_time, o_lap_valid, o_lap_full and o_lap_count update one cycle after push/pop.
- Down-count reaching zero: o_time = 0 and o_alarm = 1 appear in the same cycle, one cycle after the final o_tick.
- Asserting rst mid-run forces all outputs to 0 immediately, with no clock needed.

## Test plan
Bench parameters: CLK_HZ=1000, TICK_HZ=100, so DIV=10. Use LAP_DEPTH=4.
- Start from IDLE, wait 1000 cycles, stop -> o_time = 00:00:01.00; o_tick pulses = 100; o_run = 0 one cycle after stop.
- Pause with prescaler at 6, wait 50 cycles, start -> next advance 4 cycles after resume.
- Load 23:59:59.99 (up mode), start, 10 cycles -> o_time = 0; keeps running.
- Load with sec=63 -> reads 59.
- Mode=1, load 00:00:00.03, start -> after 30 cycles o_time = 0, o_alarm = 1, o_run = 0. Further start is ignored; clear -> IDLE, o_alarm = 0.
- Mode=1 with time 0 in IDLE, start -> stays IDLE.
- Run and push 6 laps at distinct times -> o_lap_count = 4, o_lap_full = 1, head = 3rd captured value.
- Pop 4 times -> values appear in capture order; o_lap_valid = 0; a 5th pop changes nothing.
- Same cycle: clear + lap + start -> IDLE, time 0, buffer empty.
- Same cycle: stop + tick -> no advance.
- Same cycle: push + pop when full -> count stays 4.
- Assert rst mid-RUN between clock edges -> all outputs 0 asynchronously; after release, state IDLE.
